// File: rtl/apb_arbiter_master.sv
// apb_arbiter_master: two-requester round-robin arbiter driving a single APB master port
// with an ACCESS-phase timeout that aborts stalled transfers with an error response.
module apb_arbiter_master #(
   parameter int TIMEOUT = 16
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic [1:0]       req_valid,
   input  logic [1:0]       req_write,
   input  logic [1:0][31:0] req_addr,
   input  logic [1:0][31:0] req_wdata,
   output logic [1:0]       req_ready,
   output logic [1:0]       rsp_valid,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic [31:0]      paddr,
   output logic [31:0]      pwdata,
   output logic             psel,
   output logic             penable,
   output logic             pwrite,
   input  logic             pready,
   input  logic             pslverr,
   input  logic [31:0]      prdata
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [7:0] TMO    = 8'(TIMEOUT);
   logic [1:0] state;
   logic       grant;
   logic       nxt_grant;
   logic [7:0] cnt;
   // grant register doubles as the round-robin history
   always_comb nxt_grant = (&req_valid) ? ~grant : req_valid[1];
   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= IDLE;
         grant     <= 1'b1;
         cnt       <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         case (state)
            IDLE: if (|req_valid) begin
               grant              <= nxt_grant;
               req_ready[nxt_grant] <= 1'b1;
               pwrite             <= req_write[nxt_grant];
               paddr              <= req_addr[nxt_grant];
               pwdata             <= req_wdata[nxt_grant];
               psel               <= 1'b1;
               state              <= SETUP;
            end
            SETUP: begin
               penable <= 1'b1;
               cnt     <= 8'd1;
               state   <= ACCESS;
            end
            ACCESS: if (pready || cnt == TMO) begin
               psel             <= 1'b0;
               penable          <= 1'b0;
               rsp_valid[grant] <= 1'b1;
               rsp_err          <= pready ? pslverr : 1'b1;
               rsp_rdata        <= (pready && !pwrite) ? prdata : 32'h0;
               cnt              <= '0;
               state            <= IDLE;
            end else begin
               cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/apb_arbiter_master.md
APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max ACCESS-phase cycles waited for pready before abort (legal 2..255).
REQ-002 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port preset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  per-requester transaction request; bit i = requester i.
REQ-005 SHALL have port req_write  input  2  per-requester direction, 1 = write, 0 = read.
REQ-006 SHALL have port req_addr  input  2x32  per-requester address.
REQ-007 SHALL have port req_wdata  input  2x32  per-requester write data.
REQ-008 SHALL have port req_ready  output  2  one-cycle accept pulse to requester i.
REQ-009 SHALL have port rsp_valid  output  2  one-cycle completion pulse to requester i.
REQ-010 SHALL have port rsp_rdata  output  32  read data for the completing transaction.
REQ-011 SHALL have port rsp_err  output  1  error flag for the completing transaction.
REQ-012 SHALL have ports paddr/pwdata  output  32 each; psel/penable/pwrite  output  1 each; APB master request signals.
REQ-013 SHALL have ports pready/pslverr  input  1 each; prdata  input  32; APB slave response signals.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-015 IDLE, any req_valid=1: SHALL grant one requester, latch its write/addr/wdata, pulse req_ready[grant] next cycle, enter SETUP.
REQ-016 Both valid in IDLE: SHALL grant requester not granted last (round-robin); single valid: granted regardless of history.
REQ-017 SETUP: SHALL drive psel=1, penable=0, paddr/pwrite/pwdata = latched values, exactly one cycle, then ACCESS.
REQ-018 ACCESS: SHALL drive psel=1, penable=1, paddr/pwrite/pwdata unchanged, until pready=1 sampled or timeout.
REQ-019 pready=1 sampled in ACCESS: SHALL next cycle drop psel/penable to 0, pulse rsp_valid[grant], rsp_err=pslverr, rsp_rdata=prdata for read and 0 for write; return to IDLE.
REQ-020 Timeout: SHALL count ACCESS cycles from 1; pready still 0 at count TIMEOUT -> next cycle psel=penable=0, rsp_valid[grant]=1, rsp_err=1, rsp_rdata=0, IDLE; counter cleared on every ACCESS entry.
REQ-021 pready=1 in same cycle count reaches TIMEOUT: SHALL complete normally (pready wins).
REQ-022 rsp_rdata/rsp_err SHALL hold last value between completions; rsp_valid and req_ready SHALL never exceed one cycle.
REQ-023 Minimum transaction SHALL be 3 cycles (IDLE grant, SETUP, ACCESS with pready); back-to-back grants possible in IDLE following completion.
REQ-024 req_valid changes outside IDLE SHALL be ignored; requester holds fields stable until its req_ready pulse.
REQ-025 pslverr/prdata SHALL be sampled only in the cycle pready=1 in ACCESS.

Reset
REQ-026 preset=1 SHALL set next edge: FSM=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, req_ready=rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0, last-grant=1 (requester 0 first).
REQ-027 Reset mid-transaction SHALL abort it with no rsp_valid pulse; psel drops the cycle after preset sampled.

Verification
REQ-028 Single write: req0 write addr 0x0 data 0xDEADBEEF, slave pready one ACCESS cycle -> SETUP paddr=0x0 pwdata=0xDEADBEEF psel=1 penable=0, then penable=1, rsp_valid[0]=1 rsp_err=0.
REQ-029 Read-back: req1 read addr 0x0 after prior write -> rsp_valid[1]=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 Contention: both valid continuously for 4 transactions from reset -> grant order 0,1,0,1, each req_ready single-cycle.
REQ-031 Slave error: req0 write addr 0x4, pslverr=1 with pready -> rsp_err=1, rsp_valid[0]=1, FSM back to IDLE.
REQ-032 Timeout: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-033 Reset in ACCESS: preset=1 at 3rd ACCESS cycle -> psel=penable=0 next cycle, no rsp_valid, next grant goes to requester 0.
